// File: rtl/icache_pkg.sv
// Shared widths, FSM state type and address helper for the instruction-cache
// refill controller (32 sets x 8 words, word-addressed).
package icache_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned TAG_W      = 24;
    localparam int unsigned INDEX_W    = 5;
    localparam int unsigned OFFSET_W   = 3;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned LINE_WORDS = 1 << OFFSET_W;
    localparam int unsigned LINE_W     = LINE_WORDS * WORD_W;
    localparam int unsigned CNT_W      = 32;

    typedef enum logic [2:0] {
        IDLE,
        MISS_REQ,
        REFILL,
        WRITE,
        FLUSH
    } state_e;

    // Line base address: word offset bits forced to zero.
    function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:OFFSET_W], OFFSET_W'(0)};
    endfunction

endpackage

// File: rtl/icache_line_buffer.sv
// Line assembly buffer: collects LINE_WORDS return words in ascending offset
// order. Word 0 lands in the most significant slice of line_o.
//   clk, rst   : clock, async active-high reset
//   clear_i    : drop contents and rewind the beat counter (wins over load_i)
//   load_i     : store data_i at the current beat and advance
//   data_i     : return word
//   line_o     : assembled line, word0 in [LINE_W-1 -: WORD_W]
//   beat_o     : index of the next word to be stored
//   last_c_o   : next load completes the line (beat counter at its final value)
module icache_line_buffer
    import icache_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                clear_i,
    input  logic                load_i,
    input  logic [WORD_W-1:0]   data_i,
    output logic [LINE_W-1:0]   line_o,
    output logic [OFFSET_W-1:0] beat_o,
    output logic                last_c_o
);

    logic [WORD_W-1:0]   word_q [LINE_WORDS];
    logic [OFFSET_W-1:0] beat_q;

    // Word storage and beat counter; the counter wraps to zero on completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_q <= '0;
            for (int unsigned i = 0; i < LINE_WORDS; i++) begin
                word_q[i] <= '0;
            end
        end else if (clear_i) begin
            beat_q <= '0;
            for (int unsigned i = 0; i < LINE_WORDS; i++) begin
                word_q[i] <= '0;
            end
        end else if (load_i) begin
            word_q[beat_q] <= data_i;
            beat_q         <= beat_q + OFFSET_W'(1);
        end
    end

    // Flatten words into the cache write format.
    always_comb begin
        line_o = '0;
        for (int unsigned i = 0; i < LINE_WORDS; i++) begin
            line_o[LINE_W-1-(i*WORD_W) -: WORD_W] = word_q[i];
        end
    end

    assign beat_o   = beat_q;
    assign last_c_o = (beat_q == '1);

endmodule

// File: rtl/icache_refill_ctrl.sv
// Miss/refill sequencer for the direct-mapped instruction cache.
// Stalls the core on a miss, fetches the line from memory, assembles it and
// writes data/tag/valid in one cycle; also walks all sets to invalidate them.
//   clk, reset        : clock, async active-high reset
//   fetch_valid/addr  : core fetch request (word address)
//   cache_hit         : lookup result for fetch_addr
//   stall             : core must hold its fetch (asserts combinationally on a miss)
//   mem_req/mem_addr  : line read request and line base address
//   mem_ack           : request accepted
//   mem_rvalid/rdata  : returned words, ascending offset order
//   mem_err           : refill error, abandons the refill
//   line_wr_*         : cache array write port (also carries the invalidate index)
//   inv_en            : clear valid bit at line_wr_index
//   flush             : full invalidate request pulse
//   busy              : controller not idle
//   miss_cnt          : completed refills, wrapping
module icache_refill_ctrl
    import icache_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                fetch_valid,
    input  logic [ADDR_W-1:0]   fetch_addr,
    input  logic                cache_hit,
    output logic                stall,
    output logic                mem_req,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic                mem_ack,
    input  logic                mem_rvalid,
    input  logic [WORD_W-1:0]   mem_rdata,
    input  logic                mem_err,
    output logic                line_wr_en,
    output logic [INDEX_W-1:0]  line_wr_index,
    output logic [TAG_W-1:0]    line_wr_tag,
    output logic [LINE_W-1:0]   line_wr_data,
    output logic                inv_en,
    input  logic                flush,
    output logic                busy,
    output logic [CNT_W-1:0]    miss_cnt
);

    state_e              state_q,      state_d;
    logic [ADDR_W-1:0]   base_q,       base_d;
    logic                flush_pend_q, flush_pend_d;
    logic [INDEX_W-1:0]  flush_idx_q,  flush_idx_d;
    logic [CNT_W-1:0]    miss_cnt_q,   miss_cnt_d;

    logic                buf_clear;
    logic                buf_load;
    logic                buf_last_c;
    logic [OFFSET_W-1:0] buf_beat;
    logic [LINE_W-1:0]   buf_line;
    logic                fetch_miss_c;

    assign fetch_miss_c = fetch_valid && !cache_hit;

    icache_line_buffer u_line_buf (
        .clk      (clk),
        .rst      (reset),
        .clear_i  (buf_clear),
        .load_i   (buf_load),
        .data_i   (mem_rdata),
        .line_o   (buf_line),
        .beat_o   (buf_beat),
        .last_c_o (buf_last_c)
    );

    // State and bookkeeping registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            base_q       <= '0;
            flush_pend_q <= 1'b0;
            flush_idx_q  <= '0;
            miss_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            flush_pend_q <= flush_pend_d;
            flush_idx_q  <= flush_idx_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    // Next-state logic. A flush seen while a miss is in progress is remembered
    // and serviced once the controller is free; a miss always goes first.
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        flush_pend_d = flush_pend_q;
        flush_idx_d  = flush_idx_q;
        miss_cnt_d   = miss_cnt_q;
        buf_clear    = 1'b0;
        buf_load     = 1'b0;

        case (state_q)
            IDLE: begin
                if (fetch_miss_c) begin
                    base_d  = line_base(fetch_addr);
                    state_d = MISS_REQ;
                    if (flush) begin
                        flush_pend_d = 1'b1;
                    end
                end else if (flush || flush_pend_q) begin
                    flush_pend_d = 1'b0;
                    flush_idx_d  = '0;
                    state_d      = FLUSH;
                end
            end
            MISS_REQ: begin
                if (flush) begin
                    flush_pend_d = 1'b1;
                end
                if (mem_ack) begin
                    buf_clear = 1'b1;
                    state_d   = REFILL;
                end
            end
            REFILL: begin
                if (flush) begin
                    flush_pend_d = 1'b1;
                end
                // Error abandons the partial line; the core re-misses and retries.
                if (mem_err) begin
                    buf_clear = 1'b1;
                    state_d   = IDLE;
                end else if (mem_rvalid) begin
                    buf_load = 1'b1;
                    if (buf_last_c) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                miss_cnt_d = miss_cnt_q + CNT_W'(1);
                if (flush_pend_q || flush) begin
                    flush_pend_d = 1'b0;
                    flush_idx_d  = '0;
                    state_d      = FLUSH;
                end else begin
                    state_d = IDLE;
                end
            end
            FLUSH: begin
                flush_idx_d = flush_idx_q + INDEX_W'(1);
                if (flush_idx_q == '1) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Stall covers the miss cycle itself, and is held low while in reset.
    assign stall         = !reset && ((state_q != IDLE) || fetch_miss_c);
    assign mem_req       = (state_q == MISS_REQ);
    assign mem_addr      = base_q;
    assign line_wr_en    = (state_q == WRITE);
    assign line_wr_index = (state_q == FLUSH) ? flush_idx_q
                                              : base_q[OFFSET_W +: INDEX_W];
    assign line_wr_tag   = base_q[ADDR_W-1 -: TAG_W];
    assign line_wr_data  = buf_line;
    assign inv_en        = (state_q == FLUSH);
    assign busy          = (state_q != IDLE);
    assign miss_cnt      = miss_cnt_q;

    // Beat position is only needed inside the buffer; kept visible for debug.
    logic [OFFSET_W-1:0] dbg_beat;
    assign dbg_beat = buf_beat;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl: hit, miss, gapped refill, error
// abort, flush during refill and reset mid-refill.
module tb_icache_refill_ctrl;

    logic         clk = 1'b0;
    logic         reset;
    logic         fetch_valid;
    logic [31:0]  fetch_addr;
    logic         cache_hit;
    logic         stall;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_ack;
    logic         mem_rvalid;
    logic [31:0]  mem_rdata;
    logic         mem_err;
    logic         line_wr_en;
    logic [4:0]   line_wr_index;
    logic [23:0]  line_wr_tag;
    logic [255:0] line_wr_data;
    logic         inv_en;
    logic         flush;
    logic         busy;
    logic [31:0]  miss_cnt;

    int tests  = 0;
    int fails  = 0;
    int wr_cnt = 0;

    icache_refill_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .fetch_valid   (fetch_valid),
        .fetch_addr    (fetch_addr),
        .cache_hit     (cache_hit),
        .stall         (stall),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .mem_err       (mem_err),
        .line_wr_en    (line_wr_en),
        .line_wr_index (line_wr_index),
        .line_wr_tag   (line_wr_tag),
        .line_wr_data  (line_wr_data),
        .inv_en        (inv_en),
        .flush         (flush),
        .busy          (busy),
        .miss_cnt      (miss_cnt)
    );

    always #5 clk = ~clk;

    // Count write strobes away from the active edge.
    always @(negedge clk) begin
        if (line_wr_en === 1'b1) wr_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected bench completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] mk_line(input logic [31:0] w0, input logic [31:0] step);
        logic [255:0] l;
        l = '0;
        for (int i = 0; i < 8; i++) l[255-32*i -: 32] = w0 + 32'(i) * step;
        return l;
    endfunction

    // Drives one miss from IDLE up to the WRITE cycle (or the error beat).
    task automatic miss_seq(input logic [31:0] addr, input int ack_wait, input int gap,
                            input logic [31:0] w0, input logic [31:0] step,
                            input int err_beat, input int flush_beat);
        logic [31:0] base;
        base        = {addr[31:3], 3'b000};
        fetch_valid = 1'b1;
        cache_hit   = 1'b0;
        fetch_addr  = addr;
        settle();
        chk("miss_stall_same_cycle", stall, 1);
        chk("miss_no_req_yet", mem_req, 0);
        tick();
        fetch_addr = ~addr;
        for (int i = 0; i < ack_wait; i++) begin
            settle();
            chk("req_wait", mem_req, 1);
            chk("req_wait_addr", mem_addr, base);
            tick();
        end
        mem_ack = 1'b1;
        settle();
        chk("req_at_ack", mem_req, 1);
        chk("req_addr_at_ack", mem_addr, base);
        tick();
        mem_ack = 1'b0;
        settle();
        chk("req_drop", mem_req, 0);
        for (int b = 0; b < 8; b++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = w0 + 32'(b) * step;
            mem_err    = (b + 1 == err_beat);
            flush      = (b + 1 == flush_beat);
            tick();
            mem_rvalid = 1'b0;
            mem_err    = 1'b0;
            flush      = 1'b0;
            if (b + 1 == err_beat) break;
            if (b < 7) begin
                for (int g = 1; g < gap; g++) begin
                    settle();
                    chk("gap_stall", stall, 1);
                    chk("gap_no_wr", line_wr_en, 0);
                    tick();
                end
            end
        end
        fetch_addr = addr;
    endtask

    initial begin
        reset = 1'b1; fetch_valid = 1'b0; fetch_addr = '0; cache_hit = 1'b0;
        mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_err = 1'b0; flush = 1'b0;
        #2;
        chk("rst_stall", stall, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_wr_en", line_wr_en, 0);
        chk("rst_inv_en", inv_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_miss_cnt", miss_cnt, 0);
        chk("rst_wr_data", line_wr_data, 0);
        tick(); tick();
        reset = 1'b0;

        // 1: hits never stall or request.
        fetch_valid = 1'b1; cache_hit = 1'b1; fetch_addr = 32'h0000_0105;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("t1_hit_stall", stall, 0);
            chk("t1_hit_req", mem_req, 0);
            chk("t1_hit_busy", busy, 0);
            tick();
        end

        // 2: basic miss at 0x1A2B.
        miss_seq(32'h0000_1A2B, 2, 1, 32'h11, 32'h11, 0, 0);
        settle();
        chk("t2_wr_en", line_wr_en, 1);
        chk("t2_index", line_wr_index, 5);
        chk("t2_tag", line_wr_tag, 24'h00001A);
        chk("t2_word0", line_wr_data[255:224], 32'h11);
        chk("t2_word7", line_wr_data[31:0], 32'h88);
        chk("t2_line", line_wr_data, mk_line(32'h11, 32'h11));
        chk("t2_write_stall", stall, 1);
        chk("t2_cnt_in_write", miss_cnt, 0);
        cache_hit = 1'b1;
        tick(); settle();
        chk("t2_wr_done", line_wr_en, 0);
        chk("t2_miss_cnt", miss_cnt, 1);
        chk("t2_stall_drop", stall, 0);
        chk("t2_busy", busy, 0);
        chk("t2_wr_cnt", wr_cnt, 1);

        // 3: delayed ack and gapped beats.
        miss_seq(32'h0000_1A2B, 4, 3, 32'h11, 32'h11, 0, 0);
        settle();
        chk("t3_wr_en", line_wr_en, 1);
        chk("t3_index", line_wr_index, 5);
        chk("t3_line", line_wr_data, mk_line(32'h11, 32'h11));
        chk("t3_write_stall", stall, 1);
        cache_hit = 1'b1;
        tick(); settle();
        chk("t3_stall_drop", stall, 0);
        chk("t3_miss_cnt", miss_cnt, 2);
        chk("t3_wr_cnt", wr_cnt, 2);

        // 4: error on beat 4, then retry.
        miss_seq(32'h0000_1A2B, 0, 1, 32'h11, 32'h11, 4, 0);
        settle();
        chk("t4_err_idle", busy, 0);
        chk("t4_err_no_wr", line_wr_en, 0);
        chk("t4_err_remiss_stall", stall, 1);
        chk("t4_err_cnt", miss_cnt, 2);
        chk("t4_err_wr_cnt", wr_cnt, 2);
        miss_seq(32'h0000_1A2B, 0, 1, 32'h55, 32'h10, 0, 0);
        settle();
        chk("t4_retry_wr_en", line_wr_en, 1);
        chk("t4_retry_line", line_wr_data, mk_line(32'h55, 32'h10));
        cache_hit = 1'b1;
        tick(); settle();
        chk("t4_retry_cnt", miss_cnt, 3);

        // 5: flush pulse during refill, serviced after the write.
        miss_seq(32'h0000_0040, 1, 1, 32'h1000, 32'h101, 0, 3);
        settle();
        chk("t5_wr_en", line_wr_en, 1);
        chk("t5_index", line_wr_index, 8);
        chk("t5_tag", line_wr_tag, 0);
        chk("t5_line", line_wr_data, mk_line(32'h1000, 32'h101));
        fetch_valid = 1'b0; cache_hit = 1'b0;
        tick();
        for (int i = 0; i < 32; i++) begin
            settle();
            chk("t5_inv_en", inv_en, 1);
            chk("t5_inv_idx", line_wr_index, i);
            chk("t5_busy", busy, 1);
            chk("t5_no_wr", line_wr_en, 0);
            flush = (i == 10);
            tick();
        end
        flush = 1'b0;
        settle();
        chk("t5_inv_done", inv_en, 0);
        chk("t5_idle", busy, 0);
        tick(); settle();
        chk("t5_no_reflush", inv_en, 0);
        chk("t5_miss_cnt", miss_cnt, 4);
        chk("t5_wr_cnt", wr_cnt, 4);

        // 6: reset on beat 5, then clean refill.
        fetch_valid = 1'b1; cache_hit = 1'b0; fetch_addr = 32'h0000_1A2B;
        tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        for (int b = 0; b < 4; b++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'h77 + 32'(b);
            tick();
        end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h7B;
        #2;
        reset = 1'b1;
        #1;
        chk("t6_rst_stall", stall, 0);
        chk("t6_rst_req", mem_req, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_wr_en", line_wr_en, 0);
        chk("t6_rst_inv", inv_en, 0);
        chk("t6_rst_data", line_wr_data, 0);
        chk("t6_rst_cnt", miss_cnt, 0);
        mem_rvalid = 1'b0;
        tick(); tick(); settle();
        chk("t6_rst_wr_cnt", wr_cnt, 4);
        reset = 1'b0;
        miss_seq(32'h0000_1A2B, 1, 1, 32'hA0, 32'h1, 0, 0);
        settle();
        chk("t6_wr_en", line_wr_en, 1);
        chk("t6_index", line_wr_index, 5);
        chk("t6_line", line_wr_data, mk_line(32'hA0, 32'h1));
        cache_hit = 1'b1;
        tick(); settle();
        chk("t6_miss_cnt", miss_cnt, 1);
        chk("t6_stall_drop", stall, 0);
        chk("t6_wr_cnt", wr_cnt, 5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
